// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory wait-state bridge: state encoding,
// default widths and the word-alignment mask.
package mem_bridge_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int DEPTH_LOG2 = 8;

   // Byte-offset bits that must be zero for a legal word access
   localparam logic [1:0] MISALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // True when the byte offset of an address is not word aligned
   function automatic logic isMisaligned(input logic [1:0] lowBits);
      return (lowBits & MISALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_wait_bridge_sram.sv
// Single-port word array behind the bridge. Writes are synchronous; reads
// land in an output register that holds its value until the next read.
module bridge_sram #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [DATA_W-1:0] rdata_q;

   // Array storage; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register, only updated by a read so the last word stays visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wait_bridge.sv
// Memory port for the multicycle core: accepts a read or write in IDLE,
// inserts WAIT_CYCLES wait states, performs the array access and then
// pulses ready (and err for a rejected request) for one cycle.
module mem_wait_bridge #(
   parameter int ADDR_W      = mem_bridge_pkg::ADDR_W,
   parameter int DATA_W      = mem_bridge_pkg::DATA_W,
   parameter int DEPTH_LOG2  = mem_bridge_pkg::DEPTH_LOG2,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              stall,
   output logic              err
);

   import mem_bridge_pkg::*;

   // Counter preload; the WAIT state exits when the counter reaches zero
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e                state_q,   state_d;
   logic [3:0]            waitCnt_q, waitCnt_d;
   logic                  isWrite_q, isWrite_d;
   logic                  err_q,     err_d;
   logic [DEPTH_LOG2-1:0] wordIdx_q, wordIdx_d;
   logic [DATA_W-1:0]     wdata_q,   wdata_d;

   logic sramWe;
   logic sramRe;
   logic reqValid;
   logic reqReject;

   // Upper address bits are dropped so accesses wrap modulo the depth
   logic unusedAddrBits;
   assign unusedAddrBits = ^addr[ADDR_W-1:DEPTH_LOG2+2];

   assign reqValid  = mem_read || mem_write;
   assign reqReject = isMisaligned(addr[1:0]) || (mem_read && mem_write);

   // Next-state logic: requests are only sampled in IDLE, everything after
   // that works from the latched copies
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      isWrite_d = isWrite_q;
      err_d     = err_q;
      wordIdx_d = wordIdx_q;
      wdata_d   = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (reqValid) begin
               wordIdx_d = addr[DEPTH_LOG2+1:2];
               wdata_d   = wdata;
               if (reqReject) begin
                  isWrite_d = 1'b0;
                  err_d     = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  isWrite_d = mem_write;
                  err_d     = 1'b0;
                  waitCnt_d = WAIT_INIT;
                  state_d   = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (waitCnt_q == 4'd0) begin
               state_d = ST_ACCESS;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         ST_ACCESS: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         waitCnt_q <= 4'd0;
         isWrite_q <= 1'b0;
         err_q     <= 1'b0;
         wordIdx_q <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         isWrite_q <= isWrite_d;
         err_q     <= err_d;
         wordIdx_q <= wordIdx_d;
         wdata_q   <= wdata_d;
      end
   end

   assign sramWe = (state_q == ST_ACCESS) &&  isWrite_q;
   assign sramRe = (state_q == ST_ACCESS) && !isWrite_q;

   bridge_sram #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) uSram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (sramWe),
      .re_i    (sramRe),
      .addr_i  (wordIdx_q),
      .wdata_i (wdata_q),
      .rdata_o (rdata)
   );

   // Handshake outputs decoded straight from the state
   always_comb begin
      stall = (state_q == ST_WAIT) || (state_q == ST_ACCESS) ||
              ((state_q == ST_IDLE) && reqValid);
      ready = (state_q == ST_DONE);
      err   = (state_q == ST_DONE) && err_q;
   end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Scoreboard bench for mem_wait_bridge: a slow instance (two wait states)
// and a fast instance (no wait states) driven through one set of stimulus.
module tb_mem_wait_bridge;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite;
   logic [31:0] addr, wdata;
   logic        useFast;

   logic        rdS, wrS, rdF, wrF;
   logic [31:0] rdataS, rdataF;
   logic        readyS, readyF, stallS, stallF, errS, errF;
   logic [31:0] rdataO;
   logic        readyO, stallO, errO;

   int          compared   = 0;
   int          mismatched = 0;
   exp_t        sbQ[$];
   logic [31:0] modelSlow [int];
   logic [31:0] modelFast [int];
   logic [31:0] lastSlow, lastFast;

   always #5 clk = ~clk;

   assign rdS = !useFast && memRead;
   assign wrS = !useFast && memWrite;
   assign rdF =  useFast && memRead;
   assign wrF =  useFast && memWrite;

   assign rdataO = useFast ? rdataF : rdataS;
   assign readyO = useFast ? readyF : readyS;
   assign stallO = useFast ? stallF : stallS;
   assign errO   = useFast ? errF   : errS;

   mem_wait_bridge #(.WAIT_CYCLES(2)) dutSlow (
      .clk(clk), .rst(rst), .mem_read(rdS), .mem_write(wrS),
      .addr(addr), .wdata(wdata), .rdata(rdataS), .ready(readyS),
      .stall(stallS), .err(errS)
   );

   mem_wait_bridge #(.WAIT_CYCLES(0)) dutFast (
      .clk(clk), .rst(rst), .mem_read(rdF), .mem_write(wrF),
      .addr(addr), .wdata(wdata), .rdata(rdataF), .ready(readyF),
      .stall(stallF), .err(errF)
   );

   // One complete access on the selected instance, from request to ready
   task automatic doAccess(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      exp_t got;
      int   expCycle;
      int   idx;
      bit   seen;
      idx   = int'(a[9:2]);
      e.err = (a[1:0] != 2'b00) || (rd && wr);
      expCycle = e.err ? 1 : (useFast ? 2 : 4);
      if (!e.err && wr) begin
         if (useFast) modelFast[idx] = d; else modelSlow[idx] = d;
      end
      if (!e.err && rd) begin
         if (useFast) lastFast = modelFast[idx]; else lastSlow = modelSlow[idx];
      end
      e.rdata = useFast ? lastFast : lastSlow;
      sbQ.push_back(e);
      seen = 0;
      @(negedge clk);
      memRead = rd; memWrite = wr; addr = a; wdata = d;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         compared++;
         if (stallO !== (c < expCycle)) begin
            mismatched++;
            $display("[TB] FAIL %s stall c%0d: got %b want %b", tag, c, stallO, c < expCycle);
         end
         compared++;
         if (readyO !== (c == expCycle)) begin
            mismatched++;
            $display("[TB] FAIL %s ready c%0d: got %b want %b", tag, c, readyO, c == expCycle);
         end
         if (readyO === 1'b1) begin
            got = sbQ.pop_front();
            compared++;
            if (rdataO !== got.rdata) begin
               mismatched++;
               $display("[TB] FAIL %s rdata: got %h want %h", tag, rdataO, got.rdata);
            end
            compared++;
            if (errO !== got.err) begin
               mismatched++;
               $display("[TB] FAIL %s err: got %b want %b", tag, errO, got.err);
            end
            seen = 1;
            break;
         end
      end
      memRead = 0; memWrite = 0;
      if (!seen) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s timeout: got no ready want ready", tag);
         sbQ.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1; memRead = 0; memWrite = 0; addr = 0; wdata = 0; useFast = 0;
      lastSlow = 0; lastFast = 0;
      repeat (2) @(negedge clk);
      #1;
      compared++;
      if ({readyS, errS, stallS, readyF, errF, stallF} !== 6'b0) begin
         mismatched++;
         $display("[TB] FAIL reset flags: got %b want 000000", {readyS, errS, stallS, readyF, errF, stallF});
      end
      compared++;
      if (rdataS !== 32'h0 || rdataF !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset rdata: got %h/%h want 0", rdataS, rdataF);
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_read_preloaded();
      useFast = 0;
      doAccess("preload", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
      doAccess("read0",   1'b1, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_write_then_read();
      doAccess("wr40", 1'b0, 1'b1, 32'h40, 32'h12345678);
      doAccess("rd40", 1'b1, 1'b0, 32'h40, 32'h0);
   endtask

   task automatic test_misaligned();
      doAccess("rd41",    1'b1, 1'b0, 32'h41, 32'h0);
      doAccess("wr42",    1'b0, 1'b1, 32'h42, 32'hFFFFFFFF);
      doAccess("rd40chk", 1'b1, 1'b0, 32'h40, 32'h0);
   endtask

   task automatic test_conflict();
      doAccess("wr10",   1'b0, 1'b1, 32'h10, 32'h44444444);
      doAccess("both10", 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
      doAccess("rd10",   1'b1, 1'b0, 32'h10, 32'h0);
   endtask

   task automatic test_reset_mid_write();
      useFast = 0;
      doAccess("wr20old", 1'b0, 1'b1, 32'h20, 32'h11112222);
      @(negedge clk);
      memWrite = 1; addr = 32'h20; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      rst = 1; memWrite = 0;
      #1;
      compared++;
      if ({readyS, errS, stallS} !== 3'b000 || rdataS !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL midReset: got r%b e%b s%b d%h want 000 0", readyS, errS, stallS, rdataS);
      end
      lastSlow = 0; lastFast = 0;
      @(negedge clk);
      rst = 0;
      doAccess("rd20", 1'b1, 1'b0, 32'h20, 32'h0);
   endtask

   task automatic test_wrap_and_ignore();
      exp_t e;
      exp_t got;
      useFast = 1;
      doAccess("fastWr0", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
      lastFast = modelFast[0];
      e.rdata = lastFast; e.err = 1'b0;
      sbQ.push_back(e);
      @(negedge clk);
      memRead = 1; addr = 32'h400;
      #1;
      compared++;
      if (stallO !== 1'b1 || readyO !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL wrap c0: got s%b r%b want s1 r0", stallO, readyO);
      end
      @(negedge clk);
      #1;
      compared++;
      if (stallO !== 1'b1 || readyO !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL wrap c1: got s%b r%b want s1 r0", stallO, readyO);
      end
      memRead = 0; memWrite = 1; addr = 32'h4; wdata = 32'hFFFFFFFF;
      @(negedge clk);
      #1;
      got = sbQ.pop_front();
      compared++;
      if (readyO !== 1'b1 || rdataO !== got.rdata || errO !== got.err) begin
         mismatched++;
         $display("[TB] FAIL wrap c2: got r%b d%h e%b want r1 d%h e%b", readyO, rdataO, errO, got.rdata, got.err);
      end
      memWrite = 0;
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk);
         #1;
         compared++;
         if (readyO !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wrap extra ready c%0d: got %b want 0", c, readyO);
         end
      end
      useFast = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      useFast = 0;
      for (int i = 0; i < 4; i++) begin
         addrs[i] = {22'h0, 8'(32'h80 + i * 5 + $urandom_range(0, 3) * 20), 2'b00};
         doAccess("b2bWr", 1'b0, 1'b1, addrs[i], $urandom);
      end
      for (int i = 3; i >= 0; i--) begin
         doAccess("b2bRd", 1'b1, 1'b0, addrs[i] | 32'h0000_1000, 32'h0);
      end
   endtask

   initial begin
      test_reset();
      test_read_preloaded();
      test_write_then_read();
      test_misaligned();
      test_conflict();
      test_reset_mid_write();
      test_wrap_and_ignore();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
